// File: rtl/fb_pattern_initiator.sv
// Frame-buffer pattern initiator.
// After DDR calibration, fills a V_RES x H_RES frame buffer with a background
// colour and one foreground rectangle, then hands the RAM write port over to
// the external (packet-to-RAM) writer. A fill can be re-run from PASS.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   phy_init_done       DDR calibration complete
//   reinit_req          request a new fill (honoured only in PASS)
//   e_write_*           external writer port (valid/data/address in, ready out)
//   m_write_*           RAM write port (valid/data/address out, ready in)
//   ram_init            high while the external writer owns the RAM port
//   fill_done           one-cycle pulse on entry to PASS
module fb_pattern_initiator #(
  parameter int PIX_W = 24,
  parameter int PIX_PER_WORD = 32,
  parameter int H_RES = 1024,
  parameter int V_RES = 768,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int ADDR_STEP = 16,
  parameter logic [PIX_W-1:0] BG_COLOR = 24'h252525,
  parameter logic [PIX_W-1:0] FG_COLOR = 24'h3D11AE,
  parameter int RECT_X0 = 7,
  parameter int RECT_W = 16,
  parameter int RECT_Y0 = 350,
  parameter int RECT_H = 45,
  parameter int SETTLE_CYCLES = 100,
  localparam int DATA_W = PIX_W * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phy_init_done,
  input  logic              reinit_req,
  input  logic              e_write_ram,
  input  logic [DATA_W-1:0] e_write_data,
  input  logic [ADDR_W-1:0] e_write_address,
  output logic              e_write_ready,
  output logic              m_write_ram,
  output logic [DATA_W-1:0] m_write_data,
  output logic [ADDR_W-1:0] m_write_address,
  input  logic              m_write_ready,
  output logic              ram_init,
  output logic              fill_done
);

  localparam int WPL = H_RES / PIX_PER_WORD;
  localparam int XW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int YW  = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // 64-bit bounds so RECT_X0+RECT_W (and the Y pair) cannot overflow.
  localparam logic [63:0] X_LO = 64'(RECT_X0);
  localparam logic [63:0] X_HI = 64'(RECT_X0) + 64'(RECT_W);
  localparam logic [63:0] Y_LO = 64'(RECT_Y0);
  localparam logic [63:0] Y_HI = 64'(RECT_Y0) + 64'(RECT_H);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SETTLE, S_PASS} state_t;

  state_t              state_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [SW-1:0]       settle_q;
  logic                ram_init_q;
  logic                fill_done_q;
  logic                reinit_pend_q;

  logic [XW-1:0]       x_d;
  logic [YW-1:0]       y_d;
  logic                x_last;
  logic                y_last;
  logic                hs;

  function automatic logic [DATA_W-1:0] word_for(input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y);
    logic in_rect;
    in_rect = (64'(x) >= X_LO) && (64'(x) < X_HI) &&
              (64'(y) >= Y_LO) && (64'(y) < Y_HI);
    return in_rect ? {PIX_PER_WORD{FG_COLOR}} : {PIX_PER_WORD{BG_COLOR}};
  endfunction

  always_comb begin
    x_last = (x_q == XW'(WPL - 1));
    y_last = (y_q == YW'(V_RES - 1));
    x_d    = x_last ? '0 : x_q + 1'b1;
    y_d    = x_last ? y_q + 1'b1 : y_q;
    hs     = valid_q & m_write_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      valid_q       <= 1'b0;
      data_q        <= '0;
      addr_q        <= BASE_ADDR;
      x_q           <= '0;
      y_q           <= '0;
      settle_q      <= '0;
      ram_init_q    <= 1'b0;
      fill_done_q   <= 1'b0;
      reinit_pend_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (phy_init_done) begin
            state_q <= S_FILL;
            valid_q <= 1'b1;
            data_q  <= word_for('0, '0);
            addr_q  <= BASE_ADDR;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        S_FILL: begin
          if (hs) begin
            if (x_last && y_last) begin
              valid_q <= 1'b0;
              if (SETTLE_CYCLES == 0) begin
                state_q     <= S_PASS;
                ram_init_q  <= 1'b1;
                fill_done_q <= 1'b1;
              end else begin
                state_q  <= S_SETTLE;
                settle_q <= SW'(SETTLE_CYCLES - 1);
              end
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              addr_q  <= addr_q + ADDR_W'(ADDR_STEP);
              data_q  <= word_for(x_d, y_d);
              // The next word is only offered while calibration still holds.
              valid_q <= phy_init_done;
            end
          end else if (!valid_q && phy_init_done) begin
            valid_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            state_q     <= S_PASS;
            ram_init_q  <= 1'b1;
            fill_done_q <= 1'b1;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_PASS: begin
          // Never take the port back while an external transfer is offered.
          if ((reinit_req || reinit_pend_q) && !e_write_ram) begin
            state_q       <= S_FILL;
            ram_init_q    <= 1'b0;
            reinit_pend_q <= 1'b0;
            valid_q       <= phy_init_done;
            data_q        <= word_for('0, '0);
            addr_q        <= BASE_ADDR;
            x_q           <= '0;
            y_q           <= '0;
          end else if (reinit_req) begin
            reinit_pend_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (ram_init_q) begin
      m_write_ram     = e_write_ram;
      m_write_data    = e_write_data;
      m_write_address = e_write_address;
      e_write_ready   = m_write_ready;
    end else begin
      m_write_ram     = valid_q;
      m_write_data    = data_q;
      m_write_address = addr_q;
      e_write_ready   = 1'b0;
    end
  end

  assign ram_init  = ram_init_q;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_fb_pattern_initiator.sv
module tb_fb_pattern_initiator;

  localparam int PIX_W = 24;
  localparam int PPW   = 32;
  localparam int H_RES = 128;
  localparam int V_RES = 4;
  localparam int WPL   = H_RES / PPW;
  localparam int NW    = WPL * V_RES;
  localparam int DW    = PIX_W * PPW;
  localparam int AW    = 32;
  localparam int STEP  = 16;
  localparam int RX0 = 1, RW = 2, RY0 = 1, RH = 2;
  localparam logic [23:0] BG = 24'h252525;
  localparam logic [23:0] FG = 24'h3D11AE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          phy_init_done = 1'b0;
  logic          reinit_req = 1'b0;
  logic          e_write_ram = 1'b0;
  logic [DW-1:0] e_write_data = '0;
  logic [AW-1:0] e_write_address = '0;
  logic          e_write_ready;
  logic          m_write_ram;
  logic [DW-1:0] m_write_data;
  logic [AW-1:0] m_write_address;
  logic          m_write_ready = 1'b1;
  logic          ram_init;
  logic          fill_done;

  fb_pattern_initiator #(
    .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .H_RES(H_RES), .V_RES(V_RES),
    .ADDR_W(AW), .BASE_ADDR('0), .ADDR_STEP(STEP),
    .BG_COLOR(BG), .FG_COLOR(FG),
    .RECT_X0(RX0), .RECT_W(RW), .RECT_Y0(RY0), .RECT_H(RH),
    .SETTLE_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .phy_init_done(phy_init_done),
    .reinit_req(reinit_req), .e_write_ram(e_write_ram),
    .e_write_data(e_write_data), .e_write_address(e_write_address),
    .e_write_ready(e_write_ready), .m_write_ram(m_write_ram),
    .m_write_data(m_write_data), .m_write_address(m_write_address),
    .m_write_ready(m_write_ready), .ram_init(ram_init), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got low pixel %h, expected low pixel %h", name, act[23:0], exp[23:0]);
  endtask

  // Reference: word k sits at (k mod WPL, k div WPL) and is foreground inside the rectangle.
  function automatic logic [DW-1:0] exp_data(input int k);
    int x = k % WPL;
    int y = k / WPL;
    bit in_r = (x >= RX0) && (x < RX0 + RW) && (y >= RY0) && (y < RY0 + RH);
    return in_r ? {PPW{FG}} : {PPW{BG}};
  endfunction

  // Write monitor, sampled on the falling edge.
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            rise_cyc = -1;
  int            fd_cnt = 0;
  int            fd_cyc = -1;
  logic          ri_prev = 1'b0;
  bit            stab_en = 1'b0;
  bit            rand_ready = 1'b0;
  logic          held_v = 1'b0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;

  always @(negedge clk) begin
    if (m_write_ram && m_write_ready && !ram_init) begin
      wr_addr.push_back(m_write_address);
      wr_data.push_back(m_write_data);
      wr_cyc.push_back(cyc);
    end
    if (ram_init && !ri_prev) rise_cyc = cyc;
    ri_prev = ram_init;
    if (fill_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (stab_en && held_v) begin
      check("stall_valid", 64'(m_write_ram), 64'(1));
      check("stall_addr", 64'(m_write_address), 64'(held_a));
      check_data("stall_data", m_write_data, held_d);
    end
    held_v = m_write_ram && !m_write_ready && !ram_init;
    held_a = m_write_address;
    held_d = m_write_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) m_write_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    fd_cnt = 0;
    rise_cyc = -1;
  endtask

  task automatic restart();
    reset = 1'b1;
    phy_init_done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    clear_log();
  endtask

  task automatic wait_ram_init(input string tag, input int budget);
    int n = 0;
    while (!ram_init && n < budget) begin
      step();
      n++;
    end
    check({tag, "_handover"}, 64'(ram_init), 64'(1));
  endtask

  task automatic verify_fill(input string tag);
    check({tag, "_count"}, 64'(wr_addr.size()), 64'(NW));
    for (int k = 0; k < NW && k < wr_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), 64'(wr_addr[k]), 64'(k * STEP));
      check_data($sformatf("%s_data%0d", tag, k), wr_data[k], exp_data(k));
    end
  endtask

  typedef struct {
    logic          e_ram;
    logic [AW-1:0] e_addr;
    logic          ones;
    logic          m_rdy;
    logic          x_m_ram;
    logic          x_e_rdy;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int phy_cyc, resume_cyc, sz, n;
    logic [DW-1:0] exp_d;

    tbl[0] = '{1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_2340, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_m_valid", 64'(m_write_ram), 64'(0));
    check("rst_ram_init", 64'(ram_init), 64'(0));
    check("rst_fill_done", 64'(fill_done), 64'(0));
    check("rst_addr", 64'(m_write_address), 64'(0));
    check("rst_e_ready", 64'(e_write_ready), 64'(0));
    reset = 1'b0;
    repeat (2) step();
    check("idle_no_valid", 64'(m_write_ram), 64'(0));

    // Fill with ready tied high
    clear_log();
    phy_init_done = 1'b1;
    phy_cyc = cyc;
    wait_ram_init("t1", 100);
    repeat (3) step();
    verify_fill("t1");
    if (wr_cyc.size() == NW) begin
      check("t1_first_latency", 64'(wr_cyc[0]), 64'(phy_cyc + 1));
      check("t1_back_to_back", 64'(wr_cyc[NW-1] - wr_cyc[0]), 64'(NW - 1));
      check("t1_handover_delay", 64'(rise_cyc), 64'(wr_cyc[NW-1] + 4));
    end else begin
      check("t1_write_log", 64'(wr_cyc.size()), 64'(NW));
    end
    check("t1_fill_done_width", 64'(fd_cnt), 64'(1));
    check("t1_fill_done_at_handover", 64'(fd_cyc), 64'(rise_cyc));

    // Random backpressure with stability checks
    restart();
    rand_ready = 1'b1;
    stab_en = 1'b1;
    phy_init_done = 1'b1;
    wait_ram_init("t2", 600);
    rand_ready = 1'b0;
    stab_en = 1'b0;
    m_write_ready = 1'b1;
    verify_fill("t2");

    // Calibration loss after word 7
    restart();
    phy_init_done = 1'b1;
    n = 0;
    while (wr_addr.size() < 7 && n < 100) begin
      step();
      n++;
    end
    phy_init_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t3_gap%0d", i), 64'(m_write_ram), 64'(0));
    end
    check("t3_writes_before_gap", 64'(wr_addr.size()), 64'(8));
    phy_init_done = 1'b1;
    resume_cyc = cyc;
    wait_ram_init("t3", 100);
    if (wr_cyc.size() > 8) check("t3_resume_latency", 64'(wr_cyc[8]), 64'(resume_cyc + 1));
    verify_fill("t3");

    // Pass-through mux, table vectors then random
    for (int i = 0; i < 5; i++) begin
      e_write_ram = tbl[i].e_ram;
      e_write_address = tbl[i].e_addr;
      e_write_data = tbl[i].ones ? '1 : '0;
      m_write_ready = tbl[i].m_rdy;
      #1;
      exp_d = tbl[i].ones ? '1 : '0;
      check($sformatf("tbl%0d_m_ram", i), 64'(m_write_ram), 64'(tbl[i].x_m_ram));
      check($sformatf("tbl%0d_e_ready", i), 64'(e_write_ready), 64'(tbl[i].x_e_rdy));
      check($sformatf("tbl%0d_m_addr", i), 64'(m_write_address), 64'(tbl[i].e_addr));
      check_data($sformatf("tbl%0d_m_data", i), m_write_data, exp_d);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      e_write_ram = 1'($urandom_range(0, 1));
      m_write_ready = 1'($urandom_range(0, 1));
      e_write_address = $urandom();
      for (int j = 0; j < DW / 32; j++) e_write_data[j*32 +: 32] = $urandom();
      #1;
      check("rnd_m_ram", 64'(m_write_ram), 64'(e_write_ram));
      check("rnd_e_ready", 64'(e_write_ready), 64'(m_write_ready));
      check("rnd_m_addr", 64'(m_write_address), 64'(e_write_address));
      check_data("rnd_m_data", m_write_data, e_write_data);
      step();
    end
    check("pass_ram_init_held", 64'(ram_init), 64'(1));

    // Re-init deferred behind an active external transfer
    m_write_ready = 1'b1;
    e_write_ram = 1'b1;
    e_write_address = 32'h0000_1000;
    e_write_data = '1;
    reinit_req = 1'b1;
    step();
    reinit_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_deferred%0d", i), 64'(ram_init), 64'(1));
      check($sformatf("t5_mirror%0d", i), 64'(m_write_address), 64'(32'h1000));
    end
    clear_log();
    e_write_ram = 1'b0;
    step();
    check("t5_ram_init_low", 64'(ram_init), 64'(0));
    check("t5_valid", 64'(m_write_ram), 64'(1));
    check("t5_addr0", 64'(m_write_address), 64'(0));
    wait_ram_init("t5", 100);
    repeat (2) step();
    verify_fill("t5");
    check("t5_fill_done_width", 64'(fd_cnt), 64'(1));

    // Reset during word 9
    restart();
    phy_init_done = 1'b1;
    n = 0;
    while (wr_addr.size() < 9 && n < 100) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    check("t6_valid_after_reset", 64'(m_write_ram), 64'(0));
    check("t6_ram_init_after_reset", 64'(ram_init), 64'(0));
    sz = wr_addr.size();
    repeat (3) step();
    check("t6_no_writes_in_reset", 64'(wr_addr.size()), 64'(sz));
    check("t6_idle_valid", 64'(m_write_ram), 64'(0));
    clear_log();
    reset = 1'b0;
    wait_ram_init("t6", 100);
    verify_fill("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/fb_pattern_initiator.md
Name: fb_pattern_initiator

Overview:
- Parametrised successor to the frame-buffer boot initialiser. After PHY calibration it fills a V_RES x H_RES frame buffer with a background colour plus one foreground rectangle.
- It then hands the RAM write port to the external (Ethernet) writer.
- Replaces the fixed inter-write delay with a valid/ready handshake and adds run-time re-initialisation.
- Sits between the packet-to-RAM writer and the DDR write arbiter.

Parameters:
- PIX_W, 24, bits per pixel
- PIX_PER_WORD, 32, pixels per RAM write word; DATA_W = PIX_W*PIX_PER_WORD
- H_RES, 1024, pixels per line; must be a multiple of PIX_PER_WORD; WPL = H_RES/PIX_PER_WORD
- V_RES, 768, lines per frame
- ADDR_W, 32, address width
- BASE_ADDR, 0, address of first word
- ADDR_STEP, 16, address increment per word
- BG_COLOR, 24'h252525, background pixel
- FG_COLOR, 24'h3D11AE, rectangle pixel
- RECT_X0, 7, rectangle left edge in words
- RECT_W, 16, rectangle width in words; 0 disables the rectangle
- RECT_Y0, 350, rectangle top line
- RECT_H, 45, rectangle height in lines
- SETTLE_CYCLES, 100, idle cycles between the last fill write and handover

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- phy_init_done  in  1  DDR calibration complete
- reinit_req  in  1  request a new fill; sampled while in PASS
- e_write_ram  in  1  external write valid
- e_write_data  in  DATA_W  external write data
- e_write_address  in  ADDR_W  external write address
- e_write_ready  out  1  external write accepted
- m_write_ram  out  1  write valid to RAM
- m_write_data  out  DATA_W  write data to RAM
- m_write_address  out  ADDR_W  write address to RAM
- m_write_ready  in  1  RAM accepts the write when m_write_ram & m_write_ready
- ram_init  out  1  high while the external writer owns the port
- fill_done  out  1  one-cycle pulse on entry to PASS

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE; ram_init=0; fill_done=0
  - internal valid=0, data=0, address=BASE_ADDR
  - x,y counters=0; settle counter=0
  - Reset asserted mid-fill or mid-pass aborts immediately, with no further writes.
- Output mux (combinational on ram_init):
  - ram_init=1: m_* = e_*, e_write_ready = m_write_ready.
  - Otherwise: m_* = internal, e_write_ready = 0.
- States:
  - IDLE: wait for phy_init_done=1, then go to FILL with the first word presented the next cycle.
  - FILL: internal valid high with data/address stable until the handshake (m_write_ram & m_write_ready).
  - On each handshake:
    - address += ADDR_STEP, wrapping mod 2^ADDR_W.
    - x++. When x=WPL-1, x=0 and y++.
    - Next word data = {PIX_PER_WORD{FG_COLOR}} if RECT_X0<=x<RECT_X0+RECT_W and RECT_Y0<=y<RECT_Y0+RECT_H, else {PIX_PER_WORD{BG_COLOR}}. Data is computed from the next x,y.
    - Handshake on the last word (x=WPL-1, y=V_RES-1) drops valid and goes to SETTLE.
    - Total words written = WPL*V_RES (default 24576); the first word is at BASE_ADDR.
  - phy_init_done low during FILL:
    - A pending word stays valid until accepted.
    - No new word is presented until phy_init_done returns high.
    - Counters are held.
  - SETTLE:
    - Count SETTLE_CYCLES cycles with valid=0.
    - Then ram_init=1, fill_done pulses for 1 cycle, go to PASS.
  - PASS:
    - Transparent external path.
    - If reinit_req=1 and e_write_ram=0 in the same cycle, the next cycle has ram_init=0, counters/address reset, and state is FILL.
    - If e_write_ram=1, the request is held pending and taken on the first cycle with e_write_ram=0. An external transfer is never cut mid-handshake.
    - reinit_req while not in PASS is ignored.
- Timing:
  - Latency from phy_init_done rising (in IDLE) to the first m_write_ram=1 is 1 cycle.
  - With m_write_ready tied high, a fill takes WPL*V_RES cycles, plus SETTLE_CYCLES, plus 1 to ram_init.
- Rectangle clipping:
  - Bounds beyond the frame are clipped by the compare logic.
  - Comparators are sized so RECT_X0+RECT_W does not overflow.

Test Plan:
- Small frame, ready tied high. Params: H_RES=128, PIX_PER_WORD=32, V_RES=4, RECT_X0=1, RECT_W=2, RECT_Y0=1, RECT_H=2, ADDR_STEP=16, SETTLE_CYCLES=3. Raise phy_init_done.
  - Required: exactly 16 writes at addresses 0,16,…,240.
  - Words 5,6,9,10 are all 24'h3D11AE; the rest are all 24'h252525.
  - ram_init rises 4 cycles after the last write; fill_done is a 1-cycle pulse.
- Backpressure: same params, m_write_ready toggling randomly.
  - Required: data/address stable while valid and not ready; still 16 unique writes, none duplicated or lost.
- phy_init_done dropped for 5 cycles after word 7 is accepted.
  - Required: no valid during the gap; word 8 at address 128 follows on resume.
- PASS handover: drive e_write_ram=1, address 0x1000, data all-ones.
  - Required: m_* mirrors e_* combinationally; e_write_ready follows m_write_ready.
- reinit_req while e_write_ram=1.
  - Required: the request is deferred; the first cycle with e_write_ram=0 leads to ram_init=0, then a full 16-word refill from address 0.
- Reset asserted during word 9 of a fill.
  - Required: next cycle has valid=0 and ram_init=0; after release plus phy_init_done, the fill restarts at address 0 with word 0 as background.
